regfile_sb: RTL
===============

// Module: regfile_sb
// PURPOSE
//  Parametrised CPU general-purpose register file: NUM_RD synchronous read ports, one write port.
//  Same-cycle write-to-read bypass.
//  Per-register busy scoreboard: issue claims a destination, writeback releases it.
//  Sits between decode (read/claim) and writeback (write); lets the core stall on RAW hazards
//  without external hazard logic.
// PARAMETERS
//  DATA_W    16  data width of each register, bits
//  NUM_REGS  16  number of architectural registers (>=2)
//  NUM_RD    2   number of independent read ports (>=1)
//  ZERO_REG  1   1: r0 reads 0, ignores writes and claims; 0: r0 is an ordinary register
//  AW        $clog2(NUM_REGS)  derived, address width (localparam, not overridable)
// PORTS
//  clk         in   1              rising-edge clock
//  rst_n       in   1              synchronous, active-low reset
//  rd_addr     in   NUM_RD*AW      packed read addresses; port i = [i*AW +: AW]
//  rd_data     out  NUM_RD*DATA_W  packed read data; port i = [i*DATA_W +: DATA_W], registered
//  rd_busy     out  NUM_RD         busy flag of addressed register, registered with rd_data
//  wr_en       in   1              writeback strobe
//  wr_addr     in   AW             writeback destination
//  wr_data     in   DATA_W         writeback value
//  claim_en    in   1              issue claims claim_addr as pending destination
//  claim_addr  in   AW             register being claimed
//  claim_ok    out  1              combinational: claim this cycle will be accepted
//  flush       in   1              pipeline flush: clear all busy bits
// BEHAVIOUR
//  Reset
//   - rst_n=0 at a clk edge: all registers, busy bits, rd_data and rd_busy go to 0.
//   - Reset overrides any wr_en/claim_en/flush in the same cycle.
//   - Mid-operation reset drops all pending claims.
//  Reads
//   - Latency 1: rd_data/rd_busy at edge N+1 reflect rd_addr sampled at edge N.
//   - Bypass: if wr_en && wr_addr==rd_addr[i] in the sampling cycle, rd_data[i] = wr_data (not the old value).
//   - rd_busy[i] = busy bit after that cycle's updates (write clear, claim set, flush) are applied.
//   - Out-of-range addresses (>= NUM_REGS): read 0, busy 0; writes/claims to them are ignored.
//  Writes
//   - wr_en at edge updates reg[wr_addr] and clears busy[wr_addr].
//   - Writing a non-busy register is legal: data is updated, busy stays 0.
//  Scoreboard
//   - claim_ok = !flush && (!busy[claim_addr] || (wr_en && wr_addr==claim_addr)).
//   - claim_en && claim_ok sets busy[claim_addr] at the edge.
//   - claim_en with claim_ok=0 changes nothing; the issuer must stall.
//   - Simultaneous write and claim to the same register: data written, busy ends 1 (new producer).
//   - flush: all busy bits cleared at the edge; register data untouched; same-cycle claim rejected (claim_ok=0).
//   - Same-cycle write still lands during flush.
//  Zero register (ZERO_REG=1)
//   - r0 always reads 0, rd_busy 0.
//   - Writes to r0 are dropped.
//   - Claims to r0 report claim_ok=1 and set nothing.
//  Arithmetic: no arithmetic; all compares are exact AW-bit equality.
// TESTING
//  T1 reset: preload r3=16'hBEEF, r3 claimed, pulse rst_n=0 1 cycle
//     -> read r3 gives 16'h0000, rd_busy 0.
//  T2 bypass: wr_en r5=16'h1234 while port0 and port1 both read r5 same cycle
//     -> next cycle rd_data both 16'h1234.
//  T3 RAW: claim r7 (claim_ok=1), re-claim r7 next cycle -> claim_ok=0, busy stays 1;
//     write r7=16'h00A5 -> busy 0, read 16'h00A5.
//  T4 write+claim same cycle on r2 -> r2=new data, busy 1; claim r2 in that same cycle is accepted.
//  T5 flush: claim r1,r4,r9, then flush with claim r6 -> all busy 0, claim_ok=0, r6 not busy;
//     data in r1 unchanged.
//  T6 ZERO_REG=1: write r0=16'hFFFF, claim r0 -> read r0 = 0, busy 0, claim_ok=1;
//     repeat with ZERO_REG=0, NUM_RD=3, DATA_W=32 -> r0 holds 32'hFFFF.

Source files
------------

// File: rtl/regfile_sb.sv
// Register file with NUM_RD registered read ports, one write port, write-to-read bypass and a
// per-register busy scoreboard used by issue logic to stall on RAW hazards.
module regfile_sb #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned NUM_RD   = 2,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned AW      = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD*AW-1:0]       rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr_en,
    input  logic [AW-1:0]              wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       claim_en,
    input  logic [AW-1:0]              claim_addr,
    output logic                       claim_ok,
    input  logic                       flush
);

    logic [DATA_W-1:0]        regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]      busy_q;
    logic [NUM_REGS-1:0]      busy_d;
    logic [NUM_RD*DATA_W-1:0] rd_data_d;
    logic [NUM_RD-1:0]        rd_busy_d;
    logic                     wr_hit;
    logic                     claim_hit;
    logic                     claim_busy;

    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < NUM_REGS;
    endfunction

    // A register that can hold data and be claimed: in range and not the hardwired zero.
    function automatic logic valid_dst(input logic [AW-1:0] a);
        return in_range(a) && !(ZERO_REG && (a == '0));
    endfunction

    assign claim_busy = in_range(claim_addr) ? busy_q[claim_addr] : 1'b0;
    assign claim_ok   = !flush && (!claim_busy || (wr_en && (wr_addr == claim_addr)));

    always_comb begin
        wr_hit    = wr_en && valid_dst(wr_addr);
        claim_hit = claim_en && claim_ok && valid_dst(claim_addr);
        busy_d    = busy_q;
        if (wr_hit) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (flush) begin
            busy_d = '0;
        end
        // Claim is applied last so a same-cycle write+claim leaves the new producer pending.
        if (claim_hit) begin
            busy_d[claim_addr] = 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = rd_addr[g*AW +: AW];
        assign rd_data_d[g*DATA_W +: DATA_W] = !valid_dst(ra)             ? '0      :
                                               (wr_hit && wr_addr == ra) ? wr_data :
                                                                           regs_q[ra];
        assign rd_busy_d[g] = valid_dst(ra) && busy_d[ra];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q  <= '0;
            rd_data <= '0;
            rd_busy <= '0;
        end else begin
            if (wr_hit) begin
                regs_q[wr_addr] <= wr_data;
            end
            busy_q  <= busy_d;
            rd_data <= rd_data_d;
            rd_busy <= rd_busy_d;
        end
    end

endmodule
